// File: rtl/wave_sequencer.sv
// wave_sequencer: playlist scheduler for the waveform generator configuration.
// Steps through programmed entries, holding each for a dwell counted in sample ticks.
module wave_sequencer #(
    parameter int DEPTH   = 8,
    parameter int ADDR_W  = 3,
    parameter int DWELL_W = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_sample_tick,
    input  logic                  i_wr_en,
    input  logic [ADDR_W-1:0]     i_wr_addr,
    input  logic [11+DWELL_W-1:0] i_wr_data,
    input  logic [ADDR_W:0]       i_num_entries,
    input  logic                  i_loop,
    input  logic                  i_start,
    input  logic                  i_stop,
    output logic [2:0]            o_wave_sel,
    output logic [1:0]            o_freq_sel,
    output logic [3:0]            o_duty_sel,
    output logic                  o_ampl_sel,
    output logic                  o_noise_en,
    output logic                  o_busy,
    output logic [ADDR_W-1:0]     o_step_idx,
    output logic                  o_step_pulse,
    output logic                  o_seq_done
);

    localparam int LEN_W = ADDR_W + 1;
    localparam int ENT_W = 11 + DWELL_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DWELL
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ENT_W-1:0]    r_mem [DEPTH];
    logic [DWELL_W-1:0]  r_cnt;
    logic [ADDR_W-1:0]   r_idx;
    logic [LEN_W-1:0]    r_len;
    logic [10:0]         r_cfg;
    logic                r_step_pulse;
    logic                r_seq_done;

    logic                w_wr_ok;
    logic                w_len_ok;
    logic                w_last;
    logic                w_end;
    logic                w_go;
    logic                w_apply;
    logic                w_advance;
    logic                w_wrap;
    logic                w_done;
    logic                w_count;
    logic [DWELL_W-1:0]  w_dwell;

    if (DEPTH == (1 << ADDR_W)) begin : g_full
        assign w_wr_ok = 1'b1;
    end else begin : g_part
        assign w_wr_ok = ({1'b0, i_wr_addr} < LEN_W'(DEPTH));
    end

    assign w_len_ok = (i_num_entries != '0) &&
                      (i_num_entries <= LEN_W'(DEPTH));
    assign w_last   = ({1'b0, r_idx} == (r_len - LEN_W'(1)));
    assign w_end    = i_sample_tick && (r_cnt == DWELL_W'(1));
    assign w_dwell  = r_mem[r_idx][ENT_W-1:11];

    // Entry storage has no reset so a playlist survives i_rst.
    always_ff @(posedge i_clk) begin
        if (i_wr_en && w_wr_ok)
            r_mem[i_wr_addr] <= i_wr_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_go        = 1'b0;
        w_apply     = 1'b0;
        w_advance   = 1'b0;
        w_wrap      = 1'b0;
        w_done      = 1'b0;
        w_count     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (i_start && !i_stop && w_len_ok) begin
                    w_go        = 1'b1;
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                if (i_stop) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_apply     = 1'b1;
                    w_state_nxt = S_DWELL;
                end
            end
            S_DWELL: begin
                if (i_stop) begin
                    w_state_nxt = S_IDLE;
                end else if (w_end) begin
                    if (!w_last) begin
                        w_advance   = 1'b1;
                        w_state_nxt = S_FETCH;
                    end else if (i_loop) begin
                        w_wrap      = 1'b1;
                        w_state_nxt = S_FETCH;
                    end else begin
                        w_done      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end else if (i_sample_tick) begin
                    w_count = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_len        <= '0;
            r_cfg        <= '0;
            r_step_pulse <= 1'b0;
            r_seq_done   <= 1'b0;
        end else begin
            r_step_pulse <= w_apply;
            r_seq_done   <= w_done;
            if (w_go) begin
                r_len <= i_num_entries;
                r_idx <= '0;
            end else if (w_advance) begin
                r_idx <= r_idx + ADDR_W'(1);
            end else if (w_wrap) begin
                r_idx <= '0;
            end
            // A programmed dwell of zero still lasts one tick.
            if (w_apply) begin
                r_cfg <= r_mem[r_idx][10:0];
                r_cnt <= (w_dwell == '0) ? DWELL_W'(1) : w_dwell;
            end else if (w_count) begin
                r_cnt <= r_cnt - DWELL_W'(1);
            end
        end
    end

    assign o_wave_sel   = r_cfg[10:8];
    assign o_freq_sel   = r_cfg[7:6];
    assign o_duty_sel   = r_cfg[5:2];
    assign o_ampl_sel   = r_cfg[1];
    assign o_noise_en   = r_cfg[0];
    assign o_busy       = (r_state != S_IDLE);
    assign o_step_idx   = r_idx;
    assign o_step_pulse = r_step_pulse;
    assign o_seq_done   = r_seq_done;

endmodule

// File: tb/tb_wave_sequencer.sv
// tb_wave_sequencer: directed scenarios plus random traffic for wave_sequencer,
// checked every cycle against a behavioural playlist model.
module tb_wave_sequencer;

    logic        clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_sample_tick = 1'b0;
    logic        i_wr_en = 1'b0;
    logic [2:0]  i_wr_addr = '0;
    logic [26:0] i_wr_data = '0;
    logic [3:0]  i_num_entries = '0;
    logic        i_loop = 1'b0;
    logic        i_start = 1'b0;
    logic        i_stop = 1'b0;
    logic [2:0]  o_wave_sel;
    logic [1:0]  o_freq_sel;
    logic [3:0]  o_duty_sel;
    logic        o_ampl_sel;
    logic        o_noise_en;
    logic        o_busy;
    logic [2:0]  o_step_idx;
    logic        o_step_pulse;
    logic        o_seq_done;

    wave_sequencer dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_sample_tick (i_sample_tick),
        .i_wr_en       (i_wr_en),
        .i_wr_addr     (i_wr_addr),
        .i_wr_data     (i_wr_data),
        .i_num_entries (i_num_entries),
        .i_loop        (i_loop),
        .i_start       (i_start),
        .i_stop        (i_stop),
        .o_wave_sel    (o_wave_sel),
        .o_freq_sel    (o_freq_sel),
        .o_duty_sel    (o_duty_sel),
        .o_ampl_sel    (o_ampl_sel),
        .o_noise_en    (o_noise_en),
        .o_busy        (o_busy),
        .o_step_idx    (o_step_idx),
        .o_step_pulse  (o_step_pulse),
        .o_seq_done    (o_seq_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    int tper = 0;
    int tcnt = 0;

    // Behavioural model: a running flag, a pending-fetch flag and ticks left.
    int          m_dw [8];
    logic [10:0] m_cf [8];
    logic        m_busy = 1'b0;
    logic        m_fetch = 1'b0;
    int          m_left = 0;
    int          m_len = 0;
    logic [2:0]  m_idx = '0;
    logic [10:0] m_cfg = '0;
    logic        m_pulse = 1'b0;
    logic        m_done = 1'b0;

    initial begin
        for (int i = 0; i < 8; i++) begin
            m_dw[i] = 0;
            m_cf[i] = '0;
        end
    end

    always @(posedge clk) begin
        m_pulse = 1'b0;
        m_done  = 1'b0;
        if (i_rst) begin
            m_busy  = 1'b0;
            m_fetch = 1'b0;
            m_left  = 0;
            m_idx   = '0;
            m_cfg   = '0;
        end else if (!m_busy) begin
            if (i_start && !i_stop && int'(i_num_entries) >= 1 &&
                int'(i_num_entries) <= 8) begin
                m_busy  = 1'b1;
                m_fetch = 1'b1;
                m_len   = int'(i_num_entries);
                m_idx   = '0;
            end
        end else if (i_stop) begin
            m_busy  = 1'b0;
            m_fetch = 1'b0;
        end else if (m_fetch) begin
            m_cfg   = m_cf[m_idx];
            m_left  = (m_dw[m_idx] == 0) ? 1 : m_dw[m_idx];
            m_pulse = 1'b1;
            m_fetch = 1'b0;
        end else if (i_sample_tick) begin
            if (m_left > 1) begin
                m_left = m_left - 1;
            end else if (int'(m_idx) < m_len - 1) begin
                m_idx   = m_idx + 3'd1;
                m_fetch = 1'b1;
            end else if (i_loop) begin
                m_idx   = '0;
                m_fetch = 1'b1;
            end else begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end
        if (i_wr_en) begin
            m_dw[i_wr_addr] = int'(i_wr_data[26:11]);
            m_cf[i_wr_addr] = i_wr_data[10:0];
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // One clock: compare on the falling edge, then drive after the rising edge.
    task automatic step();
        logic [16:0] act;
        logic [16:0] exp;
        @(negedge clk);
        if (chk_en) begin
            act = {o_wave_sel, o_freq_sel, o_duty_sel, o_ampl_sel,
                   o_noise_en, o_busy, o_step_idx, o_step_pulse,
                   o_seq_done};
            exp = {m_cfg, m_busy, m_idx, m_pulse, m_done};
            n_checks++;
            if (act !== exp) begin
                n_err++;
                $display("FAIL model_cycle: got %h expected %h at %0t",
                         act, exp, $time);
            end
        end
        @(posedge clk);
        #1;
        i_rst   = 1'b0;
        i_start = 1'b0;
        i_stop  = 1'b0;
        i_wr_en = 1'b0;
        tcnt++;
        if (tper < 0)
            i_sample_tick = ($urandom_range(2) == 0);
        else if (tper > 0)
            i_sample_tick = ((tcnt % tper) == 0);
        else
            i_sample_tick = 1'b0;
    endtask

    task automatic wr(input int a, input int dw, input int w, input int f,
                      input int d, input int am, input int nz);
        i_wr_en   = 1'b1;
        i_wr_addr = 3'(a);
        i_wr_data = {16'(dw), 3'(w), 2'(f), 4'(d), 1'(am), 1'(nz)};
        step();
    endtask

    task automatic start(input int n, input bit lp);
        i_num_entries = 4'(n);
        i_loop        = lp;
        i_start       = 1'b1;
        step();
    endtask

    task automatic wait_pulse(input int maxc);
        for (int c = 0; c < maxc; c++) begin
            step();
            if (o_step_pulse) return;
        end
        chk("pulse_timeout", int'(o_step_pulse), 1);
    endtask

    int np, nd, seq;
    int tk [8];

    task automatic run_seq(input int maxc, input int clr_at);
        int  nt = 0;
        bit  on = 1'b0;
        np  = 0;
        nd  = 0;
        seq = 0;
        for (int c = 0; c < maxc; c++) begin
            if (on) nt += int'(i_sample_tick);
            step();
            if (o_step_pulse) begin
                if (np > 0 && np <= 8) tk[np-1] = nt;
                np++;
                seq = seq * 10 + int'(o_step_idx) + 1;
                nt  = 0;
                on  = 1'b1;
                if (np == clr_at) i_loop = 1'b0;
            end
            if (o_seq_done) begin
                nd++;
                if (np > 0 && np <= 8) tk[np-1] = nt;
                return;
            end
        end
        chk("seq_timeout", nd, 1);
    endtask

    initial begin
        i_rst = 1'b1;
        step();
        chk_en = 1'b1;
        tper = 10;

        // Reset clears outputs but keeps entries; start latency is 2 clocks.
        wr(0, 4, 1, 2, 5, 1, 0);
        wr(1, 2, 2, 1, 3, 0, 1);
        wr(2, 1, 3, 3, 9, 1, 1);
        start(2, 1'b0);
        wait_pulse(50);
        chk("pre_rst_wave", int'(o_wave_sel), 1);
        i_rst = 1'b1;
        step();
        chk("rst_wave", int'(o_wave_sel), 0);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_duty", int'(o_duty_sel), 0);
        start(2, 1'b0);
        chk("fetch_busy", int'(o_busy), 1);
        chk("fetch_wave", int'(o_wave_sel), 0);
        step();
        chk("lat2_wave", int'(o_wave_sel), 1);
        chk("lat2_duty", int'(o_duty_sel), 5);
        chk("lat2_pulse", int'(o_step_pulse), 1);
        i_stop = 1'b1;
        step();

        // Non-loop run of three entries with dwells 4, 2, 1.
        start(3, 1'b0);
        run_seq(400, 0);
        chk("nl_pulses", np, 3);
        chk("nl_done", nd, 1);
        chk("nl_seq", seq, 123);
        chk("nl_tk0", tk[0], 4);
        chk("nl_tk1", tk[1], 2);
        chk("nl_tk2", tk[2], 1);
        chk("nl_busy", int'(o_busy), 0);
        step();
        chk("nl_hold_wave", int'(o_wave_sel), 3);
        chk("nl_hold_idx", int'(o_step_idx), 2);

        // Loop wrap 0,1,0,1 then cancel loop during the fourth entry.
        start(2, 1'b1);
        run_seq(600, 4);
        chk("lp_seq", seq, 1212);
        chk("lp_done", nd, 1);
        chk("lp_idx", int'(o_step_idx), 1);
        chk("lp_wave", int'(o_wave_sel), 2);

        // Zero dwell lasts one tick; illegal lengths are ignored.
        wr(0, 0, 5, 0, 7, 0, 1);
        start(1, 1'b0);
        run_seq(200, 0);
        chk("dw0_ticks", tk[0], 1);
        chk("dw0_wave", int'(o_wave_sel), 5);
        start(0, 1'b0);
        step();
        chk("len0_busy", int'(o_busy), 0);
        start(9, 1'b0);
        step();
        chk("len9_busy", int'(o_busy), 0);

        // Stop mid-dwell, then simultaneous start and stop from idle.
        wr(0, 4, 6, 1, 2, 1, 0);
        start(1, 1'b0);
        wait_pulse(50);
        repeat (5) step();
        i_stop = 1'b1;
        step();
        chk("stop_busy", int'(o_busy), 0);
        chk("stop_wave", int'(o_wave_sel), 6);
        chk("stop_done", int'(o_seq_done), 0);
        step();
        chk("stop_done2", int'(o_seq_done), 0);
        i_stop = 1'b1;
        start(1, 1'b0);
        chk("ss_busy", int'(o_busy), 0);
        step();
        chk("ss_busy2", int'(o_busy), 0);

        // Live rewrite of the running entry applies at its next fetch.
        wr(0, 3, 1, 0, 0, 0, 0);
        start(1, 1'b1);
        wait_pulse(50);
        step();
        wr(0, 3, 4, 0, 0, 0, 0);
        chk("live_old", int'(o_wave_sel), 1);
        repeat (5) step();
        chk("live_old2", int'(o_wave_sel), 1);
        wait_pulse(100);
        chk("live_new", int'(o_wave_sel), 4);
        i_stop = 1'b1;
        step();
        i_loop = 1'b0;

        // Random traffic against the model.
        tper = -1;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(39) == 0) begin
                i_num_entries = 4'($urandom_range(9));
                i_loop        = 1'($urandom_range(1));
                i_start       = 1'b1;
            end
            if ($urandom_range(59) == 0) i_stop = 1'b1;
            if ($urandom_range(7) == 0) begin
                i_wr_en   = 1'b1;
                i_wr_addr = 3'($urandom_range(7));
                i_wr_data = {16'($urandom_range(4)), 11'($urandom)};
            end
            if ($urandom_range(299) == 0) i_rst = 1'b1;
            step();
        end
        step();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/wave_sequencer.md
Name: wave_sequencer

Overview:
- Programmable playlist scheduler that drives the waveform generator's configuration inputs: wave select, frequency select, duty-cycle select, amplitude select and noise enable.
- Holds a small register-file of configuration entries and steps through them. Each entry is held for a programmed number of 48 kHz sample ticks.
- Sits between the button/switch front end and the wave datapath, replacing static switch settings when a sequence is running.

Parameters:
- DEPTH, 8, number of playlist entries.
- ADDR_W, 3, entry address width (log2 DEPTH).
- DWELL_W, 16, dwell counter width, in sample ticks.

Ports:
- i_clk  in  1  system clock (50 MHz domain).
- i_rst  in  1  synchronous active-high reset.
- i_sample_tick  in  1  one-cycle strobe per 48 kHz sample, already synchronous to i_clk.
- i_wr_en  in  1  write strobe for the entry register-file.
- i_wr_addr  in  ADDR_W  entry index to write.
- i_wr_data  in  11+DWELL_W  packed entry: [DWELL_W+10:11] dwell, [10:8] wave_sel, [7:6] freq_sel, [5:2] duty_sel, [1] ampl_sel, [0] noise_en.
- i_num_entries  in  ADDR_W+1  playlist length, 0..DEPTH.
- i_loop  in  1  1 = wrap to entry 0 after the last entry; 0 = stop after the last entry.
- i_start  in  1  start pulse.
- i_stop  in  1  stop pulse.
- o_wave_sel  out  3  current wave select.
- o_freq_sel  out  2  current frequency select.
- o_duty_sel  out  4  current duty-cycle select.
- o_ampl_sel  out  1  current amplitude select.
- o_noise_en  out  1  current noise enable.
- o_busy  out  1  high in FETCH or DWELL.
- o_step_idx  out  ADDR_W  index of the active entry.
- o_step_pulse  out  1  one-cycle pulse when a new entry's config is applied.
- o_seq_done  out  1  one-cycle pulse when a non-loop sequence completes.

Behaviour:
- Reset (synchronous, i_rst=1 at a clock edge):
  - all outputs go to 0; state = IDLE; dwell counter = 0.
  - register-file contents are NOT cleared.
- Register-file writes:
  - take effect at the clock edge where i_wr_en=1, in any state.
  - i_wr_addr >= DEPTH: the write is ignored.
- State IDLE:
  - i_start=1 and 1 <= i_num_entries <= DEPTH: latch length, step_idx <= 0, go to FETCH.
  - i_num_entries=0 or > DEPTH: i_start is ignored.
  - Config outputs hold their last values.
- State FETCH (exactly 1 cycle):
  - read entry[step_idx] and register all five config outputs.
  - load counter = max(dwell, 1), so a dwell of 0 is treated as 1.
  - o_step_pulse=1 in the cycle after FETCH, coincident with the new outputs.
  - go to DWELL.
- State DWELL:
  - each i_sample_tick decrements the counter.
  - when a tick arrives with counter==1, the entry ends:
    - if step_idx < length-1: step_idx++ and go to FETCH.
    - else if i_loop=1: step_idx <= 0 and go to FETCH.
    - else: o_seq_done pulse and go to IDLE, holding the last config.
- Latency: from i_start to new config at the outputs is 2 cycles (IDLE→FETCH edge, FETCH→DWELL edge).
- Stop and start priority:
  - i_stop in FETCH or DWELL: go to IDLE next edge; outputs hold; no o_seq_done.
  - i_stop and i_start asserted together: stop wins.
  - i_start while busy is ignored.
- Live writes: writing the active entry does not alter the running dwell or outputs; the new value applies at its next FETCH.
- Length latching: i_num_entries and i_loop are sampled at start. i_loop is re-sampled at each wrap decision, so loop can be cancelled live.
- Ticks: a tick in the FETCH cycle is not counted. Dwell length is measured in ticks, not clocks.
- o_busy = (state != IDLE).

Test Plan:
- Reset hold: write entries, pulse i_rst, then i_start with length 2 → outputs 0 until the FETCH edge; entries are preserved; first config appears 2 cycles after start.
- Non-loop run: 3 entries with dwell 4, 2, 1 and ticks every 10 clocks → o_step_idx goes 0,1,2. Transitions occur after 4, 2 and 1 ticks. o_step_pulse occurs ×3, o_seq_done ×1, then o_busy=0 with entry 2's config held.
- Loop wrap: length 2, i_loop=1 → the index sequence is 0,1,0,1. Clear i_loop during entry 1 → finishes with o_seq_done after entry 1.
- Dwell 0 and illegal length: entry with dwell=0 → held for exactly 1 tick. i_start with i_num_entries=0 or 9 (DEPTH=8) → remains IDLE.
- Stop mid-dwell plus simultaneous start/stop: i_stop during DWELL → IDLE next cycle, config held, no o_seq_done. i_start and i_stop in the same cycle from IDLE → remains IDLE.
- Live write: rewrite the active entry's wave_sel from 1 to 4 mid-dwell → output stays 1 until the next FETCH of that index, then shows 4.
